// File: rtl/coreriscv_axi4_locking_demux.sv
// Grant demultiplexer: routes one registered grant entry to client 0 or 1,
// locking the route for the duration of a multi-beat grant burst.
module coreriscv_axi4_locking_demux #(
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic [2:0]  io_in_bits_addr_beat,
  input  logic [1:0]  io_in_bits_client_xact_id,
  input  logic        io_in_bits_manager_xact_id,
  input  logic        io_in_bits_is_builtin_type,
  input  logic [3:0]  io_in_bits_g_type,
  input  logic [63:0] io_in_bits_data,
  input  logic        io_in_bits_client_id,
  input  logic        io_out_0_ready,
  output logic        io_out_0_valid,
  output logic [2:0]  io_out_0_bits_addr_beat,
  output logic [1:0]  io_out_0_bits_client_xact_id,
  output logic        io_out_0_bits_manager_xact_id,
  output logic        io_out_0_bits_is_builtin_type,
  output logic [3:0]  io_out_0_bits_g_type,
  output logic [63:0] io_out_0_bits_data,
  output logic        io_out_0_bits_client_id,
  input  logic        io_out_1_ready,
  output logic        io_out_1_valid,
  output logic [2:0]  io_out_1_bits_addr_beat,
  output logic [1:0]  io_out_1_bits_client_xact_id,
  output logic        io_out_1_bits_manager_xact_id,
  output logic        io_out_1_bits_is_builtin_type,
  output logic [3:0]  io_out_1_bits_g_type,
  output logic [63:0] io_out_1_bits_data,
  output logic        io_out_1_bits_client_id,
  output logic        io_locked,
  output logic        io_err_route
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Output entry
  logic          r_full;
  logic          r_dest;
  logic [2:0]    r_addr_beat;
  logic [1:0]    r_client_xact_id;
  logic          r_manager_xact_id;
  logic          r_is_builtin_type;
  logic [3:0]    r_g_type;
  logic [63:0]   r_data;
  logic          r_client_id;

  // Burst lock state
  logic [CW-1:0] r_cnt;
  logic          r_lock;
  logic          r_err;

  logic w_sel_ready;
  logic w_drain;
  logic w_accept;
  logic w_multi;
  logic w_locked;
  logic w_route;

  assign w_sel_ready = r_dest ? io_out_1_ready : io_out_0_ready;
  assign w_drain     = r_full & w_sel_ready;
  assign io_in_ready = ~r_full | w_drain;
  assign w_accept    = io_in_valid & io_in_ready;
  assign w_multi     = io_in_bits_is_builtin_type ? (io_in_bits_g_type == 4'h5)
                                                  : (io_in_bits_g_type == 4'h0);
  assign w_locked    = (r_cnt != '0);
  assign w_route     = w_locked ? r_lock : io_in_bits_client_id;

  assign io_locked    = w_locked;
  assign io_err_route = r_err;

  assign io_out_0_valid = r_full & ~r_dest;
  assign io_out_1_valid = r_full & r_dest;

  assign io_out_0_bits_addr_beat       = r_addr_beat;
  assign io_out_0_bits_client_xact_id  = r_client_xact_id;
  assign io_out_0_bits_manager_xact_id = r_manager_xact_id;
  assign io_out_0_bits_is_builtin_type = r_is_builtin_type;
  assign io_out_0_bits_g_type          = r_g_type;
  assign io_out_0_bits_data            = r_data;
  assign io_out_0_bits_client_id       = r_client_id;

  assign io_out_1_bits_addr_beat       = r_addr_beat;
  assign io_out_1_bits_client_xact_id  = r_client_xact_id;
  assign io_out_1_bits_manager_xact_id = r_manager_xact_id;
  assign io_out_1_bits_is_builtin_type = r_is_builtin_type;
  assign io_out_1_bits_g_type          = r_g_type;
  assign io_out_1_bits_data            = r_data;
  assign io_out_1_bits_client_id       = r_client_id;

  // Entry occupancy and destination; a fill takes priority over a same-cycle drain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_dest <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_dest <= w_route;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

  // Payload capture; no reset since contents are only meaningful while full
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr_beat       <= io_in_bits_addr_beat;
      r_client_xact_id  <= io_in_bits_client_xact_id;
      r_manager_xact_id <= io_in_bits_manager_xact_id;
      r_is_builtin_type <= io_in_bits_is_builtin_type;
      r_g_type          <= io_in_bits_g_type;
      r_data            <= io_in_bits_data;
      r_client_id       <= io_in_bits_client_id;
    end
  end

  // Burst beat counting, lock capture and sticky misroute detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_lock <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if (w_locked || w_multi) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (!w_locked && w_multi) begin
        r_lock <= io_in_bits_client_id;
      end
      if (w_locked && (!w_multi || (io_in_bits_client_id != r_lock))) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coreriscv_axi4_locking_demux.sv
// Self-checking bench for coreriscv_axi4_locking_demux.
module tb_coreriscv_axi4_locking_demux;

  localparam int BEATS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic        io_out_0_ready, io_out_1_ready;
  logic        io_out_0_valid, io_out_1_valid;
  logic        io_locked, io_err_route;
  logic [75:0] in_pl;

  // Packed payload layout: {addr_beat[3], cxid[2], mxid, builtin, g_type[4], data[64], client_id}
  logic [2:0]  o0_ab, o1_ab;
  logic [1:0]  o0_cx, o1_cx;
  logic        o0_mx, o1_mx, o0_bi, o1_bi, o0_cid, o1_cid;
  logic [3:0]  o0_gt, o1_gt;
  logic [63:0] o0_d, o1_d;
  logic [75:0] out0_pl, out1_pl;
  assign out0_pl = {o0_ab, o0_cx, o0_mx, o0_bi, o0_gt, o0_d, o0_cid};
  assign out1_pl = {o1_ab, o1_cx, o1_mx, o1_bi, o1_gt, o1_d, o1_cid};

  coreriscv_axi4_locking_demux #(.BEATS(BEATS)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .io_in_ready                   (io_in_ready),
    .io_in_valid                   (io_in_valid),
    .io_in_bits_addr_beat          (in_pl[75:73]),
    .io_in_bits_client_xact_id     (in_pl[72:71]),
    .io_in_bits_manager_xact_id    (in_pl[70]),
    .io_in_bits_is_builtin_type    (in_pl[69]),
    .io_in_bits_g_type             (in_pl[68:65]),
    .io_in_bits_data               (in_pl[64:1]),
    .io_in_bits_client_id          (in_pl[0]),
    .io_out_0_ready                (io_out_0_ready),
    .io_out_0_valid                (io_out_0_valid),
    .io_out_0_bits_addr_beat       (o0_ab),
    .io_out_0_bits_client_xact_id  (o0_cx),
    .io_out_0_bits_manager_xact_id (o0_mx),
    .io_out_0_bits_is_builtin_type (o0_bi),
    .io_out_0_bits_g_type          (o0_gt),
    .io_out_0_bits_data            (o0_d),
    .io_out_0_bits_client_id       (o0_cid),
    .io_out_1_ready                (io_out_1_ready),
    .io_out_1_valid                (io_out_1_valid),
    .io_out_1_bits_addr_beat       (o1_ab),
    .io_out_1_bits_client_xact_id  (o1_cx),
    .io_out_1_bits_manager_xact_id (o1_mx),
    .io_out_1_bits_is_builtin_type (o1_bi),
    .io_out_1_bits_g_type          (o1_gt),
    .io_out_1_bits_data            (o1_d),
    .io_out_1_bits_client_id       (o1_cid),
    .io_locked                     (io_locked),
    .io_err_route                  (io_err_route)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one held entry plus "beats left in the current burst"
  logic        m_full = 1'b0, m_dest = 1'b0, m_lock = 1'b0, m_err = 1'b0;
  int          m_left = 0;
  logic [75:0] m_pl = '0;
  logic        last_acc;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [75:0] mkpl(input logic cid, input logic bi,
                                       input logic [3:0] gt, input logic [63:0] d);
    logic [2:0] ab;
    logic [1:0] cx;
    logic       mx;
    ab = 3'($urandom);
    cx = 2'($urandom);
    mx = 1'($urandom);
    return {ab, cx, mx, bi, gt, d, cid};
  endfunction

  // Inputs are set at posedge+1; checks happen at posedge+2; returns at next posedge+1
  task automatic cycle();
    logic exp_rdy, acc, multi, cid;
    #1;
    exp_rdy = !m_full || (m_dest ? io_out_1_ready : io_out_0_ready);
    chk("in_ready", 76'(io_in_ready), 76'(exp_rdy));
    chk("out0_valid", 76'(io_out_0_valid), 76'(m_full && !m_dest));
    chk("out1_valid", 76'(io_out_1_valid), 76'(m_full && m_dest));
    if (m_full) chk("out_payload", m_dest ? out1_pl : out0_pl, m_pl);
    chk("locked", 76'(io_locked), 76'(m_left != 0));
    chk("err_route", 76'(io_err_route), 76'(m_err));
    acc = io_in_valid && exp_rdy;
    last_acc = acc && !reset;
    if (!reset && io_out_0_valid && io_out_0_ready) q0.push_back(o0_d);
    if (!reset && io_out_1_valid && io_out_1_ready) q1.push_back(o1_d);
    if (reset) begin
      m_full = 1'b0; m_left = 0; m_lock = 1'b0; m_err = 1'b0;
    end else if (acc) begin
      cid   = in_pl[0];
      multi = in_pl[69] ? (in_pl[68:65] == 4'h5) : (in_pl[68:65] == 4'h0);
      if (m_left > 0) begin
        m_dest = m_lock;
        if (!multi || cid != m_lock) m_err = 1'b1;
        m_left--;
      end else begin
        m_dest = cid;
        if (multi) begin
          m_left = BEATS - 1;
          m_lock = cid;
        end
      end
      m_full = 1'b1;
      m_pl   = in_pl;
    end else if (m_full && (m_dest ? io_out_1_ready : io_out_0_ready)) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold one beat until accepted, with random stalls on out_0; bounded
  task automatic send_beat(input logic [75:0] pl);
    io_in_valid = 1'b1;
    in_pl = pl;
    last_acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      io_out_0_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: beat %h not accepted within 100 cycles", pl);
    end
    io_in_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic        cid;
    logic        bi;
    logic [3:0]  gt;
    logic [63:0] d;
    logic        e_v0;
    logic        e_v1;
    logic [63:0] e_d;
    logic        e_lk;
    logic        e_err;
  } vec_t;

  vec_t vt[9];

  initial begin
    // rst vld cid bi gt d | v0 v1 data lk err   (expected after the edge)
    vt[0] = '{1, 0, 0, 0, 4'h0, 64'h0,  0, 0, 64'h0,  0, 0};
    vt[1] = '{0, 1, 1, 1, 4'h0, 64'hA5, 0, 1, 64'hA5, 0, 0};
    vt[2] = '{0, 0, 0, 0, 4'h0, 64'h0,  0, 0, 64'h0,  0, 0};
    vt[3] = '{0, 1, 0, 1, 4'h5, 64'h1,  1, 0, 64'h1,  1, 0};
    vt[4] = '{0, 1, 0, 0, 4'h1, 64'h2,  1, 0, 64'h2,  1, 1};
    vt[5] = '{0, 0, 0, 0, 4'h0, 64'h0,  0, 0, 64'h0,  1, 1};
    vt[6] = '{1, 0, 0, 0, 4'h0, 64'h0,  0, 0, 64'h0,  0, 0};
    vt[7] = '{0, 1, 1, 0, 4'h0, 64'h3,  0, 1, 64'h3,  1, 0};
    vt[8] = '{1, 0, 0, 0, 4'h0, 64'h0,  0, 0, 64'h0,  0, 0};

    reset = 1'b1;
    io_in_valid = 1'b0;
    in_pl = '0;
    io_out_0_ready = 1'b1;
    io_out_1_ready = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      reset = vt[i].rst;
      io_in_valid = vt[i].vld;
      in_pl = mkpl(vt[i].cid, vt[i].bi, vt[i].gt, vt[i].d);
      cycle();
      chk($sformatf("vec%0d_v0", i), 76'(io_out_0_valid), 76'(vt[i].e_v0));
      chk($sformatf("vec%0d_v1", i), 76'(io_out_1_valid), 76'(vt[i].e_v1));
      chk($sformatf("vec%0d_locked", i), 76'(io_locked), 76'(vt[i].e_lk));
      chk($sformatf("vec%0d_err", i), 76'(io_err_route), 76'(vt[i].e_err));
      if (vt[i].e_v0) chk($sformatf("vec%0d_data", i), 76'(o0_d), 76'(vt[i].e_d));
      if (vt[i].e_v1) chk($sformatf("vec%0d_data", i), 76'(o1_d), 76'(vt[i].e_d));
    end
    reset = 1'b0;
    io_in_valid = 1'b0;

    // Clean 8-beat burst to client 0 with random out_0 stalls
    q0.delete();
    q1.delete();
    for (int b = 0; b < BEATS; b++) begin
      send_beat(mkpl(1'b0, 1'b0, 4'h0, 64'(100 + b)));
      chk("burst_locked", 76'(io_locked), 76'(b != BEATS - 1));
    end
    io_out_0_ready = 1'b1;
    cycle();
    chk("burst_count", 76'(q0.size()), 76'(BEATS));
    for (int b = 0; b < BEATS && b < q0.size(); b++)
      chk("burst_order", 76'(q0[b]), 76'(100 + b));
    chk("burst_no_out1", 76'(q1.size()), 76'(0));
    chk("burst_err_clear", 76'(io_err_route), 76'(0));

    // Same burst with beat 4 carrying the wrong client_id
    q0.delete();
    for (int b = 0; b < BEATS; b++)
      send_beat(mkpl(b == 3, 1'b0, 4'h0, 64'(200 + b)));
    io_out_0_ready = 1'b1;
    cycle();
    chk("mis_count_out0", 76'(q0.size()), 76'(BEATS));
    if (q0.size() > 3) chk("mis_beat4_out0", 76'(q0[3]), 76'(203));
    chk("mis_err", 76'(io_err_route), 76'(1));
    chk("mis_unlocked", 76'(io_locked), 76'(0));

    // Back-to-back singles alternating client_id
    q0.delete();
    q1.delete();
    for (int i = 0; i < 16; i++) begin
      io_in_valid = 1'b1;
      in_pl = mkpl(1'(i), 1'b1, 4'h3, 64'(300 + i));
      cycle();
      chk("tput_accept", 76'(last_acc), 76'(1));
    end
    io_in_valid = 1'b0;
    cycle();
    chk("tput_delivered", 76'(q0.size() + q1.size()), 76'(16));

    // Backpressure on out_1
    io_out_1_ready = 1'b0;
    io_in_valid = 1'b1;
    in_pl = mkpl(1'b1, 1'b1, 4'h4, 64'hB0);
    cycle();
    in_pl = mkpl(1'b0, 1'b1, 4'h4, 64'hB1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready_low", 76'(io_in_ready), 76'(0));
      chk("bp_hold_valid", 76'(io_out_1_valid), 76'(1));
      chk("bp_hold_data", 76'(o1_d), 76'(64'hB0));
    end
    io_out_1_ready = 1'b1;
    #1;
    chk("bp_release_ready", 76'(io_in_ready), 76'(1));
    cycle();
    chk("bp_new_valid0", 76'(io_out_0_valid), 76'(1));
    chk("bp_new_data", 76'(o0_d), 76'(64'hB1));
    chk("bp_old_gone", 76'(io_out_1_valid), 76'(0));
    io_in_valid = 1'b0;
    cycle();
    chk("err_sticky", 76'(io_err_route), 76'(1));

    // Reset in the middle of a burst
    io_in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_pl = mkpl(1'b0, 1'b0, 4'h0, 64'(400 + b));
      cycle();
    end
    io_in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_locked", 76'(io_locked), 76'(0));
    chk("rst_v0", 76'(io_out_0_valid), 76'(0));
    chk("rst_v1", 76'(io_out_1_valid), 76'(0));
    io_in_valid = 1'b1;
    in_pl = mkpl(1'b1, 1'b0, 4'h1, 64'hC1);
    cycle();
    chk("rst_route_v1", 76'(io_out_1_valid), 76'(1));
    chk("rst_route_data", 76'(o1_d), 76'(64'hC1));

    // Randomized traffic against the model
    begin
      logic cid_r, bi_r;
      logic [3:0] gt_r;
      cid_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        reset = ($urandom_range(0, 199) == 0);
        io_in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) cid_r = 1'($urandom);
        bi_r = 1'($urandom);
        case ($urandom_range(0, 2))
          0: gt_r = 4'h0;
          1: gt_r = 4'h5;
          default: gt_r = 4'($urandom);
        endcase
        in_pl = mkpl(cid_r, bi_r, gt_r, {$urandom, $urandom});
        io_out_0_ready = ($urandom_range(0, 3) != 0);
        io_out_1_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coreriscv_axi4_locking_demux.md
CORERISCV_AXI4_LOCKING_DEMUX -- requirements
Module: CORERISCV_AXI4_LOCKING_DEMUX

Interface
REQ-001 SHALL have parameter BEATS, default 8, meaning data beats per multi-beat grant (power of two; beat counter width = log2(BEATS) = 3).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port io_in_ready  output  1  grant stream accept.
REQ-005 SHALL have port io_in_valid  input  1  grant beat present.
REQ-006 SHALL have ports io_in_bits_addr_beat[3], _client_xact_id[2], _manager_xact_id[1], _is_builtin_type[1], _g_type[4], _data[64], _client_id[1], all inputs, meaning grant payload.
REQ-007 SHALL have, for k in {0,1}, port io_out_k_ready  input  1  downstream accept for client k.
REQ-008 SHALL have, for k in {0,1}, port io_out_k_valid  output  1  beat present for client k.
REQ-009 SHALL have, for k in {0,1}, ports io_out_k_bits_* as outputs, with the same names and widths as REQ-006, carrying the registered payload.
REQ-010 SHALL have port io_locked  output  1  high while a multi-beat grant is in progress.
REQ-011 SHALL have port io_err_route  output  1  sticky mid-burst client_id mismatch flag.

Function
REQ-012 SHALL hold one registered output entry: full_q, dest_q, payload_q.
REQ-013 SHALL define accept = io_in_valid & io_in_ready, and drain = full_q & io_out_<dest_q>_ready.
REQ-014 SHALL drive io_in_ready = !full_q | drain, which allows a drain and a fill in the same cycle (one beat per cycle).
REQ-015 SHALL drive io_out_k_valid = full_q & (dest_q == k); the non-selected output's valid SHALL stay 0.
REQ-016 SHALL drive both io_out_k_bits from payload_q; bits are don't-care when valid is low.
REQ-017 SHALL make a beat appear on the output the cycle after accept (latency 1).
REQ-018 SHALL define multi = is_builtin_type ? (g_type == 4'h5) : (g_type == 4'h0), evaluated on the input beat.
REQ-019 SHALL keep a 3-bit beat counter cnt_q and a lock destination lock_q.
REQ-020 SHALL route the accepted beat to lock_q when cnt_q != 0, and to in_client_id otherwise.
REQ-021 SHALL, on an accepted multi beat: set cnt_q to cnt_q + 1 modulo 8, and load lock_q from in_client_id when cnt_q == 0.
REQ-022 SHALL release the lock (cnt_q returns to 0) on the 8th accepted multi beat; the next beat SHALL then route by its own client_id.
REQ-023 SHALL NOT change cnt_q on an accepted single-beat (non-multi) grant when cnt_q == 0.
REQ-024 SHALL treat an accepted non-multi beat while cnt_q != 0 as a burst beat: count it, route it to lock_q, and set io_err_route.
REQ-025 SHALL set io_err_route when cnt_q != 0 and the accepted beat's client_id != lock_q; the beat SHALL still go to lock_q.
REQ-026 SHALL keep io_err_route set until reset.
REQ-027 SHALL drive io_locked = (cnt_q != 0).
REQ-028 SHALL ignore addr_beat for routing and counting; it passes through unchanged.
REQ-029 SHALL hold full_q, dest_q and payload_q stable while full_q and the selected output is not ready.
REQ-030 SHALL update cnt_q only on accept; stalls SHALL NOT advance the counter.

Reset
REQ-031 SHALL, on reset: full_q=0, cnt_q=0, lock_q=0, io_err_route=0. Hence io_out_k_valid=0, io_locked=0 and io_in_ready=1 in the first cycle after reset.
REQ-032 SHALL NOT reset payload_q; its value is don't-care.
REQ-033 SHALL let reset asserted mid-burst abandon the burst and discard any held entry; the next beat after reset SHALL route by its own client_id.

Verification
REQ-034 Single beat: builtin g_type=4'h0, client_id=1, data=64'hA5, both outputs ready -> next cycle io_out_1_valid=1 with data A5; io_out_0_valid=0; io_locked stays 0.
REQ-035 Burst: 8 beats, non-builtin g_type=0, client_id=0, random out_0 stalls -> all 8 beats on out_0 in order; io_locked high from after beat 1 until after beat 8; cnt_q=0 afterwards.
REQ-036 Mismatch: same burst with beat 4's client_id=1 -> beat 4 delivered on out_0; io_err_route=1 and stays 1 through the end of the test.
REQ-037 Throughput: back-to-back single beats alternating client_id, both outputs always ready -> io_in_ready stays 1 and one beat delivered per cycle.
REQ-038 Backpressure: io_out_1_ready=0 with out_1 entry held -> io_in_ready=0 and payload stable; raise ready -> drain and new accept in the same cycle.
REQ-039 Reset mid-burst: reset after beat 3 of a burst -> io_locked=0, outputs invalid; the next beat with client_id=1 routes to out_1.
